// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access.
// Fixed priority (data over inst) with grant lock; in-order ID FIFO routes responses back.
module mem_port_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // instruction fetch side
  input  logic          inst_req_i,
  input  logic [AW-1:0] inst_addr_i,
  output logic          inst_addr_ok_o,
  output logic          inst_data_ok_o,
  output logic [31:0]   inst_rdata_o,
  input  logic          inst_cancel_i,
  // data side
  input  logic          data_req_i,
  input  logic          data_wr_i,
  input  logic [1:0]    data_size_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [3:0]    data_wstrb_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_addr_ok_o,
  output logic          data_data_ok_o,
  output logic [31:0]   data_rdata_o,
  // downstream memory port
  output logic          mem_req_o,
  output logic          mem_wr_o,
  output logic [1:0]    mem_size_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_wstrb_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_addr_ok_i,
  input  logic          mem_data_ok_i,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {IdInst = 1'b0, IdData = 1'b1} id_e;

  logic                   lock_q, lock_d;
  id_e                    owner_q, owner_d;
  logic [OUTSTANDING-1:0] id_q, id_d;
  logic [OUTSTANDING-1:0] disc_q, disc_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  id_e                    grant;
  logic                   gnt_req;
  logic                   full;
  logic                   accept;
  logic                   pop;
  logic                   head_id;
  logic                   head_disc;
  logic [OUTSTANDING-1:0] valid;

  // A presented-but-unaccepted request keeps the port until it is accepted or withdrawn.
  always_comb begin
    grant = IdInst;
    if (lock_q) begin
      grant = owner_q;
    end else if (data_req_i) begin
      grant = IdData;
    end
  end

  assign gnt_req   = (grant == IdData) ? data_req_i : inst_req_i;
  assign full      = (cnt_q == CntW'(OUTSTANDING));
  assign mem_req_o = resetn & gnt_req & ~full;
  assign accept    = mem_req_o & mem_addr_ok_i;
  assign pop       = resetn & mem_data_ok_i & (cnt_q != '0);
  assign head_id   = id_q[rd_ptr_q];
  assign head_disc = disc_q[rd_ptr_q];

  always_comb begin
    for (int unsigned i = 0; i < OUTSTANDING; i++) begin
      logic [PtrW-1:0] off;
      off      = PtrW'(i) - rd_ptr_q;
      valid[i] = ({1'b0, off} < cnt_q);
    end
  end

  // Next-state logic
  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    id_d     = id_q;
    disc_d   = disc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d  = 1'b1;
      owner_d = grant;
    end else if (!gnt_req) begin
      lock_d = 1'b0;
    end

    // Cancel only hits entries already present; the entry pushed this cycle is the redirect.
    if (inst_cancel_i) begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        if (valid[i] && (id_q[i] == IdInst)) begin
          disc_d[i] = 1'b1;
        end
      end
    end

    if (accept) begin
      id_d[wr_ptr_q]   = grant;
      disc_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q   <= 1'b0;
      owner_q  <= IdInst;
      id_q     <= '0;
      disc_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      id_q     <= id_d;
      disc_q   <= disc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs
  always_comb begin
    inst_addr_ok_o = accept & (grant == IdInst);
    data_addr_ok_o = accept & (grant == IdData);
    data_data_ok_o = pop & (head_id == IdData);
    inst_data_ok_o = pop & (head_id == IdInst) & ~head_disc & ~inst_cancel_i;
    inst_rdata_o   = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    if (grant == IdData) begin
      mem_wr_o    = data_wr_i;
      mem_size_o  = data_size_i;
      mem_addr_o  = data_addr_i;
      mem_wstrb_o = data_wstrb_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_wr_o    = 1'b0;
      mem_size_o  = 2'd2;
      mem_addr_o  = inst_addr_i;
      mem_wstrb_o = 4'b0000;
      mem_wdata_o = 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based transaction model.
module tb_mem_port_arbiter;

  localparam int unsigned Outstanding = 4;
  localparam int unsigned Aw          = 32;

  logic          clk;
  logic          resetn;
  logic          inst_req, inst_addr_ok, inst_data_ok, inst_cancel;
  logic [Aw-1:0] inst_addr;
  logic [31:0]   inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [Aw-1:0] data_addr;
  logic [3:0]    data_wstrb;
  logic [31:0]   data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]    mem_size;
  logic [Aw-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .OUTSTANDING(Outstanding),
    .AW         (Aw)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .inst_req_i    (inst_req),
    .inst_addr_i   (inst_addr),
    .inst_addr_ok_o(inst_addr_ok),
    .inst_data_ok_o(inst_data_ok),
    .inst_rdata_o  (inst_rdata),
    .inst_cancel_i (inst_cancel),
    .data_req_i    (data_req),
    .data_wr_i     (data_wr),
    .data_size_i   (data_size),
    .data_addr_i   (data_addr),
    .data_wstrb_i  (data_wstrb),
    .data_wdata_i  (data_wdata),
    .data_addr_ok_o(data_addr_ok),
    .data_data_ok_o(data_data_ok),
    .data_rdata_o  (data_rdata),
    .mem_req_o     (mem_req),
    .mem_wr_o      (mem_wr),
    .mem_size_o    (mem_size),
    .mem_addr_o    (mem_addr),
    .mem_wstrb_o   (mem_wstrb),
    .mem_wdata_o   (mem_wdata),
    .mem_addr_ok_i (mem_addr_ok),
    .mem_data_ok_i (mem_data_ok),
    .mem_rdata_i   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One entry per accepted-but-unanswered transaction, oldest first.
  typedef struct {
    bit is_data;
    bit disc;
  } txn_t;
  txn_t q[$];

  // Requester that was presented to memory but not yet accepted keeps the port.
  bit held_v;
  bit held_data;

  bit drop_inst, drop_data;
  int p_ok, p_dok;

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1000;
    inst_cancel = 1'b0;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'h2000;
    data_wstrb  = 4'hf;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h12345678;
    held_v      = 1'b0;
    held_data   = 1'b0;
    drop_inst   = 1'b0;
    drop_data   = 1'b0;

    // Reset holds every handshake output low even with all inputs asserted.
    @(negedge clk);
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_inst_addr_ok", inst_addr_ok, 0);
    check_eq("rst_data_addr_ok", data_addr_ok, 0);
    check_eq("rst_inst_data_ok", inst_data_ok, 0);
    check_eq("rst_data_data_ok", data_data_ok, 0);
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      unique case ((cyc / 500) % 4)
        0: begin p_ok = 70; p_dok = 70; end
        1: begin p_ok = 85; p_dok = 12; end
        2: begin p_ok = 25; p_dok = 80; end
        default: begin p_ok = 50; p_dok = 50; end
      endcase

      @(negedge clk);
      if (drop_inst) inst_req = 1'b0;
      if (drop_data) data_req = 1'b0;
      drop_inst = 1'b0;
      drop_data = 1'b0;

      if (!inst_req && ($urandom_range(99) < 50)) begin
        inst_req  = 1'b1;
        inst_addr = $urandom & 32'hffff_fffc;
      end
      if (!data_req && ($urandom_range(99) < 40)) begin
        data_req   = 1'b1;
        data_wr    = $urandom_range(1);
        data_size  = 2'($urandom_range(2));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(99) < p_ok);
      mem_data_ok = ($urandom_range(99) < p_dok);
      mem_rdata   = $urandom;
      inst_cancel = ($urandom_range(99) < 8);
      resetn      = ($urandom_range(399) != 0);
      #1;

      if (!resetn) begin
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_inst_addr_ok", inst_addr_ok, 0);
        check_eq("rst_data_addr_ok", data_addr_ok, 0);
        check_eq("rst_inst_data_ok", inst_data_ok, 0);
        check_eq("rst_data_data_ok", data_data_ok, 0);
        q.delete();
        held_v    = 1'b0;
        drop_inst = 1'b1;
        drop_data = 1'b1;
      end else begin
        bit g_data, greq, e_req, e_acc, pop, e_iok, e_dok;
        g_data = held_v ? held_data : data_req;
        greq   = g_data ? data_req : inst_req;
        e_req  = greq && (q.size() < Outstanding);
        e_acc  = e_req && mem_addr_ok;
        pop    = mem_data_ok && (q.size() > 0);
        e_dok  = pop && q[0].is_data;
        e_iok  = pop && !q[0].is_data && !q[0].disc && !inst_cancel;

        check_eq("mem_req", mem_req, e_req);
        check_eq("inst_addr_ok", inst_addr_ok, e_acc && !g_data);
        check_eq("data_addr_ok", data_addr_ok, e_acc && g_data);
        check_eq("inst_data_ok", inst_data_ok, e_iok);
        check_eq("data_data_ok", data_data_ok, e_dok);
        check_eq("inst_rdata", inst_rdata, mem_rdata);
        check_eq("data_rdata", data_rdata, mem_rdata);
        if (e_req) begin
          check_eq("mem_addr", mem_addr, g_data ? data_addr : inst_addr);
          check_eq("mem_wr", mem_wr, g_data ? data_wr : 1'b0);
          check_eq("mem_size", mem_size, g_data ? data_size : 2'd2);
          check_eq("mem_wstrb", mem_wstrb, g_data ? data_wstrb : 4'h0);
          check_eq("mem_wdata", mem_wdata, g_data ? data_wdata : 32'h0);
        end

        if (pop) void'(q.pop_front());
        if (inst_cancel) begin
          foreach (q[i]) if (!q[i].is_data) q[i].disc = 1'b1;
        end
        if (e_acc) q.push_back('{is_data: g_data, disc: 1'b0});

        if (e_acc) begin
          held_v = 1'b0;
        end else if (e_req) begin
          held_v    = 1'b1;
          held_data = g_data;
        end else if (!greq) begin
          held_v = 1'b0;
        end

        if (e_acc && g_data)  drop_data = 1'b1;
        if (e_acc && !g_data) drop_inst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
